// File: rtl/write_response_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// write_response_ctrl_pkg
// Shared AXI write-response definitions used by the response ordering
// controller and the B-channel response mux:
//   b_state_e   : response-mux select encoding (IDLE, B_M1_S0, B_M1_S1)
//   slave_idx_t : decoded slave index carried through the order queue
//   state_for_slave() : maps a slave index to the mux select that serves it
// -----------------------------------------------------------------------------
package write_response_ctrl_pkg;

    // Response-mux select; B_RSVD is never entered in normal operation.
    typedef enum logic [1:0] {
        B_IDLE  = 2'd0,
        B_M1_S0 = 2'd1,
        B_M1_S1 = 2'd2,
        B_RSVD  = 2'd3
    } b_state_e;

    localparam int unsigned SLAVE_IDX_W = 1;

    typedef logic [SLAVE_IDX_W-1:0] slave_idx_t;

    // Select value that routes the given slave's B channel to master M1.
    function automatic b_state_e state_for_slave(input slave_idx_t idx);
        b_state_e st;
        case (idx)
            1'b0:    st = B_M1_S0;
            1'b1:    st = B_M1_S1;
            default: st = B_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/write_response_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// b_order_fifo
// In-order queue of slave indices, one entry per accepted write address.
// Parameters:
//   DEPTH : number of entries, power of two, 2..16
//   WIDTH : entry width in bits
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (clears pointers/count)
//   push, din   : enqueue request and data; ignored while full, even if a pop
//                 happens in the same cycle
//   pop         : dequeue request; ignored while empty
//   head        : entry at the read pointer
//   head_next   : entry one behind the head (valid when count >= 2); lets the
//                 consumer pick its next target in the same cycle as a pop
//   full, empty : combinational decode of the registered count
//   count       : registered number of stored entries
// Storage contents are deliberately not reset.
// -----------------------------------------------------------------------------
module b_order_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 1,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] head_next,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_s;
    logic             empty_s;
    logic             push_acc_s;
    logic             pop_acc_s;

    assign full_s     = (count_q == CNT_W'(DEPTH));
    assign empty_s    = (count_q == CNT_W'(0));
    // Fullness is judged before any same-cycle pop, so a full queue never
    // accepts a push.
    assign push_acc_s = push & ~full_s;
    assign pop_acc_s  = pop & ~empty_s;

    // Pointer and count next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_acc_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_acc_s, pop_acc_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (push_acc_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign head_next = mem_q[rd_ptr_q + PTR_ONE];
    assign full      = full_s;
    assign empty     = empty_s;
    assign count     = count_q;

endmodule

// File: rtl/write_response_ctrl.sv
// -----------------------------------------------------------------------------
// write_response_ctrl
// Orders write responses from two slaves (S0, S1) back to master M1 in the
// order the write addresses were issued.
// Parameter:
//   DEPTH : maximum outstanding writes, power of two, 2..16
// Ports:
//   ACLK, ARESETn : clock, asynchronous active-low reset
//   AW_push       : AW handshake completed this cycle
//   AW_slave      : target of that handshake (0 = S0, 1 = S1)
//   AW_full       : queue full, used by the interconnect to gate AWREADY
//   BVALID_S0/S1  : write-response valid from each slave
//   BREADY_M1     : write-response ready from the master
//   B_state       : registered response-mux select
//   outstanding   : registered count of queued, unretired writes
//   ovf_err       : sticky flag, AW_push seen while AW_full
// -----------------------------------------------------------------------------
module write_response_ctrl
    import write_response_ctrl_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             AW_push,
    input  logic             AW_slave,
    output logic             AW_full,
    input  logic             BVALID_S0,
    input  logic             BVALID_S1,
    input  logic             BREADY_M1,
    output logic [1:0]       B_state,
    output logic [CNT_W-1:0] outstanding,
    output logic             ovf_err
);

    b_state_e         state_q, state_d;
    logic             ovf_q, ovf_d;
    logic             retire_s;
    logic             push_acc_s;
    logic             remain_s;
    slave_idx_t       new_head_s;
    slave_idx_t       fifo_head_s;
    slave_idx_t       fifo_head_next_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;

    b_order_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SLAVE_IDX_W)
    ) u_order_fifo (
        .clk       (ACLK),
        .rst_n     (ARESETn),
        .push      (AW_push),
        .din       (AW_slave),
        .pop       (retire_s),
        .head      (fifo_head_s),
        .head_next (fifo_head_next_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Retire condition: only the slave currently selected can complete.
    always_comb begin
        retire_s = 1'b0;
        case (state_q)
            B_M1_S0: retire_s = BVALID_S0 & BREADY_M1;
            B_M1_S1: retire_s = BVALID_S1 & BREADY_M1;
            default: retire_s = 1'b0;
        endcase
    end

    // Whether anything is left after a pop, and which slave it targets. With
    // a single stored entry the only possible survivor is the push arriving
    // in the same cycle.
    always_comb begin
        push_acc_s = AW_push & ~fifo_full_s;
        remain_s   = (fifo_count_s > CNT_W'(1)) | push_acc_s;
        if (fifo_count_s > CNT_W'(1)) begin
            new_head_s = fifo_head_next_s;
        end else begin
            new_head_s = AW_slave;
        end
    end

    // Next-state logic and sticky overflow flag.
    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q | (AW_push & fifo_full_s);
        case (state_q)
            B_IDLE: begin
                if (!fifo_empty_s) begin
                    state_d = state_for_slave(fifo_head_s);
                end else begin
                    state_d = B_IDLE;
                end
            end
            B_M1_S0, B_M1_S1: begin
                if (retire_s) begin
                    if (remain_s) begin
                        state_d = state_for_slave(new_head_s);
                    end else begin
                        state_d = B_IDLE;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = B_IDLE;
        endcase
    end

    // State and error-flag registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= B_IDLE;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    assign B_state     = state_q;
    assign ovf_err     = ovf_q;
    assign outstanding = fifo_count_s;
    assign AW_full     = fifo_full_s;

endmodule
